riscv_multicycle_ctrl: RTL and testbench

- Moore-style FSM (one Mealy term in BRANCH) that sequences a multicycle RV64 subset datapath.
- Inputs are decoded IR fields plus the ALU zero flag; outputs are all register enables, memory controls, mux selects, ALU op and current state code.
- Sits between the instruction register and every datapath mux/register.

---
 rtl/cu_pkg.sv | 61 ++++++
 rtl/cu_decode.sv | 50 +++++
 rtl/riscv_multicycle_ctrl.sv | 146 ++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle RV64 control unit:
// state codes, opcode/funct fields, ALU ops and datapath mux selects.
package cu_pkg;

    typedef enum logic [5:0] {
        S_RESET      = 6'd0,
        S_FETCH      = 6'd1,
        S_FETCH_WAIT = 6'd2,
        S_IR_LOAD    = 6'd3,
        S_DECODE     = 6'd4,
        S_R_EXEC     = 6'd5,
        S_ALU_WB     = 6'd6,
        S_ADDI_EXEC  = 6'd7,
        S_MEM_ADDR   = 6'd8,
        S_LD_READ    = 6'd9,
        S_LD_MDR     = 6'd10,
        S_LD_WB      = 6'd11,
        S_SD_WRITE   = 6'd12,
        S_BRANCH     = 6'd13,
        S_PC_INC     = 6'd14,
        S_LUI_WB     = 6'd15
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_DW  = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    localparam logic [3:0] IORD_PC       = 4'd0;
    localparam logic [3:0] IORD_ALUOUT   = 4'd1;
    localparam logic [3:0] MTR_ALUOUT    = 4'd0;
    localparam logic [3:0] MTR_MDR       = 4'd1;
    localparam logic [3:0] MTR_IMM       = 4'd2;
    localparam logic [3:0] SRCA_PC       = 4'd0;
    localparam logic [3:0] SRCA_A        = 4'd1;
    localparam logic [3:0] SRCB_B        = 4'd0;
    localparam logic [3:0] SRCB_FOUR     = 4'd1;
    localparam logic [3:0] SRCB_IMM      = 4'd2;
    localparam logic [3:0] SRCB_ZEXT     = 4'd3;
    localparam logic [3:0] PCSRC_ALU     = 4'd0;
    localparam logic [3:0] PCSRC_ALUOUT  = 4'd1;
    localparam logic [3:0] PCSRC_IMM     = 4'd2;

endpackage

// File: rtl/cu_decode.sv
// Combinational IR decode: dispatch state out of DECODE and the R-type ALU op.
// Zero latency; CU_BNE_EN adds bne to the branch dispatch.
module cu_decode
    import cu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [5:0] dispatch,
    output logic [2:0] r_alu_op
);

    logic r_valid;

    always_comb begin
        r_alu_op = ALU_ADD;
        r_valid  = 1'b1;
        if (funct3 == F3_ADD && funct7 == F7_ADD) begin
            r_alu_op = ALU_ADD;
        end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
            r_alu_op = ALU_SUB;
        end else if (funct3 == F3_AND) begin
            r_alu_op = ALU_AND;
        end else if (funct3 == F3_XOR) begin
            r_alu_op = ALU_XOR;
        end else begin
            r_valid = 1'b0;
        end
    end

    // Anything not recognised retires as a NOP through PC_INC.
    always_comb begin
        dispatch = S_PC_INC;
        case (opcode)
            OP_RTYPE:           if (r_valid) dispatch = S_R_EXEC;
            OP_IMM:             if (funct3 == F3_ADD) dispatch = S_ADDI_EXEC;
            OP_LOAD, OP_STORE:  if (funct3 == F3_DW) dispatch = S_MEM_ADDR;
            OP_BRANCH: begin
`ifdef CU_BNE_EN
                if (funct3 == F3_BEQ || funct3 == F3_BNE) dispatch = S_BRANCH;
`else
                if (funct3 == F3_BEQ) dispatch = S_BRANCH;
`endif
            end
            OP_LUI:             dispatch = S_LUI_WB;
            default:            dispatch = S_PC_INC;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV64-subset control FSM: Moore outputs per state, PCWrite Mealy on Zero in BRANCH.
// One state per cycle; CU_BNE_EN enables bne (taken when Zero=0).
module riscv_multicycle_ctrl
    import cu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       AWrite,
    output logic       BWrite,
    output logic       AluOutWrite,
    output logic       MDRWrite,
    output logic       MemRead,
    output logic       DMemReadWrite,
    output logic [3:0] IorD,
    output logic [3:0] MemtoReg,
    output logic [3:0] AluSrcA,
    output logic [3:0] AluSrcB,
    output logic [3:0] PCSource,
    output logic [2:0] ALUOpOut,
    output logic [5:0] State_out
);

    state_t     state, state_next;
    logic [5:0] dispatch;
    logic [2:0] r_alu_op;
    logic       br_taken;

    cu_decode u_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .dispatch (dispatch),
        .r_alu_op (r_alu_op)
    );

`ifdef CU_BNE_EN
    assign br_taken = (funct3 == F3_BNE) ? ~Zero : Zero;
`else
    assign br_taken = Zero;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_RESET;
        else        state <= state_next;
    end

    assign State_out = state;
    assign MemRead   = 1'b0;

    always_comb begin
        state_next    = S_RESET;
        PCWrite       = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        AWrite        = 1'b0;
        BWrite        = 1'b0;
        AluOutWrite   = 1'b0;
        MDRWrite      = 1'b0;
        DMemReadWrite = 1'b0;
        IorD          = IORD_PC;
        MemtoReg      = MTR_ALUOUT;
        AluSrcA       = SRCA_PC;
        AluSrcB       = SRCB_B;
        PCSource      = PCSRC_ALU;
        ALUOpOut      = ALU_PASSA;
        case (state)
            S_RESET:      state_next = S_FETCH;
            S_FETCH:      state_next = S_FETCH_WAIT;
            S_FETCH_WAIT: state_next = S_IR_LOAD;
            S_IR_LOAD: begin
                IRWrite    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                AWrite      = 1'b1;
                BWrite      = 1'b1;
                AluSrcB     = SRCB_IMM;
                ALUOpOut    = ALU_ADD;
                AluOutWrite = 1'b1;
                state_next  = state_t'(dispatch);
            end
            S_R_EXEC: begin
                AluSrcA     = SRCA_A;
                ALUOpOut    = r_alu_op;
                AluOutWrite = 1'b1;
                state_next  = S_ALU_WB;
            end
            S_ADDI_EXEC: begin
                AluSrcA     = SRCA_A;
                AluSrcB     = SRCB_IMM;
                ALUOpOut    = ALU_ADD;
                AluOutWrite = 1'b1;
                state_next  = S_ALU_WB;
            end
            S_MEM_ADDR: begin
                AluSrcA     = SRCA_A;
                AluSrcB     = SRCB_IMM;
                ALUOpOut    = ALU_ADD;
                AluOutWrite = 1'b1;
                state_next  = (opcode == OP_STORE) ? S_SD_WRITE : S_LD_READ;
            end
            S_LD_READ:    state_next = S_LD_MDR;
            S_LD_MDR: begin
                MDRWrite   = 1'b1;
                state_next = S_LD_WB;
            end
            S_BRANCH: begin
                AluSrcA  = SRCA_A;
                ALUOpOut = ALU_SUB;
                if (br_taken) begin
                    PCWrite    = 1'b1;
                    PCSource   = PCSRC_ALUOUT;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_PC_INC;
                end
            end
            // Retiring states: each bumps PC by 4 on the way back to FETCH.
            S_ALU_WB, S_LD_WB, S_SD_WRITE, S_PC_INC, S_LUI_WB: begin
                AluSrcB    = SRCB_FOUR;
                ALUOpOut   = ALU_ADD;
                PCWrite    = 1'b1;
                state_next = S_FETCH;
                if (state == S_ALU_WB) RegWrite = 1'b1;
                if (state == S_LD_WB) begin
                    RegWrite = 1'b1;
                    MemtoReg = MTR_MDR;
                end
                if (state == S_SD_WRITE) DMemReadWrite = 1'b1;
                if (state == S_LUI_WB) begin
                    RegWrite = 1'b1;
                    MemtoReg = MTR_IMM;
                end
            end
            default:      state_next = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: walks each instruction class through the FSM
// and checks state sequence and key control outputs against hand-derived values.
module tb_riscv_multicycle_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       Zero = 1'b0;
    logic       PCWrite, IRWrite, RegWrite, AWrite, BWrite, AluOutWrite, MDRWrite;
    logic       MemRead, DMemReadWrite;
    logic [3:0] IorD, MemtoReg, AluSrcA, AluSrcB, PCSource;
    logic [2:0] ALUOpOut;
    logic [5:0] State_out;
    logic [31:0] all_outs;

    int tests = 0;
    int fails = 0;

    riscv_multicycle_ctrl dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .AWrite(AWrite), .BWrite(BWrite), .AluOutWrite(AluOutWrite), .MDRWrite(MDRWrite),
        .MemRead(MemRead), .DMemReadWrite(DMemReadWrite), .IorD(IorD), .MemtoReg(MemtoReg),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .PCSource(PCSource), .ALUOpOut(ALUOpOut),
        .State_out(State_out)
    );

    always #5 clock = ~clock;

    assign all_outs = {PCWrite, IRWrite, RegWrite, AWrite, BWrite, AluOutWrite, MDRWrite,
                       MemRead, DMemReadWrite, IorD, MemtoReg, AluSrcA, AluSrcB, PCSource,
                       ALUOpOut};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic z);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        Zero   = z;
    endtask

    // From FETCH, step through FETCH_WAIT, IR_LOAD and DECODE.
    task automatic fetch_to_decode(input string tag);
        check({tag, "_fetch"}, State_out, 32'd1);
        tick(); check({tag, "_fwait"}, State_out, 32'd2);
        tick(); check({tag, "_irload"}, State_out, 32'd3);
        check({tag, "_irwrite3"}, IRWrite, 32'd1);
        tick(); check({tag, "_decode"}, State_out, 32'd4);
        check({tag, "_dec_ctl"}, {IRWrite, AWrite, BWrite, AluOutWrite, AluSrcA, AluSrcB, ALUOpOut},
              {1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 3'b001});
    endtask

    initial begin
        #12;
        check("rst_state", State_out, 32'd0);
        check("rst_outs", all_outs, 32'd0);
        @(negedge clock) reset = 1'b1;

        set_ir(7'b0110011, 3'b000, 7'b0100000, 1'b0);
        tick(); check("boot_fetch", State_out, 32'd1);
        check("fetch_iord", IorD, 32'd0);
        check("fetch_irwrite", IRWrite, 32'd0);
        fetch_to_decode("sub");
        tick(); check("sub_rexec", State_out, 32'd5);
        check("sub_aluop", ALUOpOut, 32'b010);
        check("sub_srca", AluSrcA, 32'd1);
        tick(); check("sub_aluwb", State_out, 32'd6);
        check("sub_wb_ctl", {RegWrite, PCWrite, MemtoReg, AluSrcB, PCSource}, {1'b1, 1'b1, 4'd0, 4'd1, 4'd0});
        tick(); check("sub_back", State_out, 32'd1);

        set_ir(7'b0110011, 3'b111, 7'b0000000, 1'b0);
        fetch_to_decode("and");
        tick(); check("and_rexec", State_out, 32'd5);
        check("and_aluop", ALUOpOut, 32'b011);
        tick(); tick(); check("and_back", State_out, 32'd1);

        set_ir(7'b0110011, 3'b001, 7'b0000000, 1'b0);
        fetch_to_decode("rbad");
        tick(); check("rbad_pcinc", State_out, 32'd14);
        check("rbad_regwrite", RegWrite, 32'd0);
        tick(); check("rbad_back", State_out, 32'd1);

        set_ir(7'b0010011, 3'b000, 7'b0000000, 1'b0);
        fetch_to_decode("addi");
        tick(); check("addi_exec", State_out, 32'd7);
        check("addi_ctl", {AluSrcA, AluSrcB, ALUOpOut, AluOutWrite}, {4'd1, 4'd2, 3'b001, 1'b1});
        tick(); check("addi_wb", State_out, 32'd6);
        tick(); check("addi_back", State_out, 32'd1);

        set_ir(7'b0000011, 3'b011, 7'b0000000, 1'b0);
        fetch_to_decode("ld");
        tick(); check("ld_addr", State_out, 32'd8);
        tick(); check("ld_read", State_out, 32'd9);
        check("ld_dmem9", DMemReadWrite, 32'd0);
        tick(); check("ld_mdr", State_out, 32'd10);
        check("ld_mdrwrite", MDRWrite, 32'd1);
        tick(); check("ld_wb", State_out, 32'd11);
        check("ld_wb_ctl", {RegWrite, MemtoReg, DMemReadWrite, PCWrite}, {1'b1, 4'd1, 1'b0, 1'b1});
        tick(); check("ld_back", State_out, 32'd1);

        fetch_to_decode("ldrst");
        tick(); tick(); check("ldrst_read", State_out, 32'd9);
        #2 reset = 1'b0;
        #1 check("ldrst_state", State_out, 32'd0);
        check("ldrst_outs", all_outs, 32'd0);
        tick(); check("ldrst_hold", State_out, 32'd0);
        @(negedge clock) reset = 1'b1;
        tick(); check("ldrst_fetch", State_out, 32'd1);

        set_ir(7'b0100011, 3'b011, 7'b0000000, 1'b0);
        fetch_to_decode("sd");
        tick(); check("sd_addr", State_out, 32'd8);
        check("sd_dmem8", DMemReadWrite, 32'd0);
        tick(); check("sd_write", State_out, 32'd12);
        check("sd_ctl", {DMemReadWrite, RegWrite, PCWrite}, {1'b1, 1'b0, 1'b1});
        tick(); check("sd_back", State_out, 32'd1);
        check("sd_dmem1", DMemReadWrite, 32'd0);

        set_ir(7'b1100011, 3'b000, 7'b0000000, 1'b1);
        fetch_to_decode("beqt");
        tick(); check("beqt_branch", State_out, 32'd13);
        check("beqt_ctl", {PCWrite, PCSource, AluSrcA, ALUOpOut}, {1'b1, 4'd1, 4'd1, 3'b010});
        tick(); check("beqt_back", State_out, 32'd1);

        set_ir(7'b1100011, 3'b000, 7'b0000000, 1'b0);
        fetch_to_decode("beqn");
        tick(); check("beqn_branch", State_out, 32'd13);
        check("beqn_pcwrite", PCWrite, 32'd0);
        tick(); check("beqn_pcinc", State_out, 32'd14);
        check("beqn_inc_ctl", {PCWrite, PCSource}, {1'b1, 4'd0});
        tick(); check("beqn_back", State_out, 32'd1);

        set_ir(7'b0110111, 3'b000, 7'b0000000, 1'b0);
        fetch_to_decode("lui");
        tick(); check("lui_wb", State_out, 32'd15);
        check("lui_ctl", {RegWrite, MemtoReg, PCWrite}, {1'b1, 4'd2, 1'b1});
        tick(); check("lui_back", State_out, 32'd1);

        set_ir(7'b1111111, 3'b000, 7'b0000000, 1'b0);
        fetch_to_decode("nop");
        tick(); check("nop_pcinc", State_out, 32'd14);
        check("nop_regwrite", RegWrite, 32'd0);
        tick(); check("nop_back", State_out, 32'd1);

        set_ir(7'b1100011, 3'b001, 7'b0000000, 1'b0);
        fetch_to_decode("bne");
        tick();
`ifdef CU_BNE_EN
        check("bne_branch", State_out, 32'd13);
        check("bne_taken", {PCWrite, PCSource}, {1'b1, 4'd1});
`else
        check("bne_nop", State_out, 32'd14);
        check("bne_nop_pcsrc", PCSource, 32'd0);
`endif
        tick(); check("bne_back", State_out, 32'd1);
        check("memread_zero", MemRead, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
